// File: rtl/tlc_param_controller_pkg.sv
// Shared state codes, lamp encodings and lamp decode
// for the parametrised two-road traffic-light controller.
package tlc_param_controller_pkg;

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_LG  = 3'd3;
  localparam logic [2:0] S_LY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] l;
  } lamps_t;

  // Illegal codes show highway green so lamps stay one-hot
  function automatic lamps_t lamp_decode(input logic [2:0] st);
    lamps_t lp;
    lp.h = LAMP_G;
    lp.l = LAMP_R;
    case (st)
      S_HY: begin
        lp.h = LAMP_Y;
        lp.l = LAMP_R;
      end
      S_AR1, S_AR2: begin
        lp.h = LAMP_R;
        lp.l = LAMP_R;
      end
      S_LG: begin
        lp.h = LAMP_R;
        lp.l = LAMP_G;
      end
      S_LY: begin
        lp.h = LAMP_R;
        lp.l = LAMP_Y;
      end
      default: begin
        lp.h = LAMP_G;
        lp.l = LAMP_R;
      end
    endcase
    return lp;
  endfunction

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchronizer with active-low async reset.
// Used for the local-road sensor when TLC_SENSOR_SYNC_EN is defined.
module tlc_sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tlc_param_controller.sv
// Two-road traffic-light FSM with min/max greens and all-red clearance.
// TLC_SENSOR_SYNC_EN adds a 2-flop sensor synchronizer.
module tlc_param_controller
  import tlc_param_controller_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int GREEN_MIN_H = 8,
  parameter int GREEN_MIN_L = 4,
  parameter int GREEN_MAX_L = 12,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SENSOR,
  output logic [2:0] H,
  output logic [2:0] L,
  output logic [2:0] STATE
);

  localparam int T_MAX = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] C_GMH =
    CNT_W'(GREEN_MIN_H > 0 ? GREEN_MIN_H - 1 : 0);
  localparam logic [CNT_W-1:0] C_GML =
    CNT_W'(GREEN_MIN_L > 0 ? GREEN_MIN_L - 1 : 0);
  localparam logic [CNT_W-1:0] C_GXL =
    CNT_W'(GREEN_MAX_L > 0 ? GREEN_MAX_L - 1 : 0);
  localparam logic [CNT_W-1:0] C_YEL =
    CNT_W'(YELLOW_T > 0 ? YELLOW_T - 1 : 0);
  localparam logic [CNT_W-1:0] C_ARD =
    CNT_W'(ALLRED_T > 0 ? ALLRED_T - 1 : 0);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SAT = '1;

  if (GREEN_MIN_L > GREEN_MAX_L || ALLRED_T == 0 ||
      GREEN_MIN_H > T_MAX || GREEN_MIN_L > T_MAX ||
      GREEN_MAX_L > T_MAX || YELLOW_T > T_MAX ||
      ALLRED_T > T_MAX) begin : g_param_err
    $error("tlc_param_controller: invalid timing parameters");
  end

  logic             w_sens;
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_timer;
  lamps_t           w_lamps;

`ifdef TLC_SENSOR_SYNC_EN
  tlc_sync2 #(
    .W(1)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_d    (SENSOR),
    .o_q    (w_sens)
  );
`else
  assign w_sens = SENSOR;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HG:
        if (r_timer >= C_GMH && w_sens)
          w_next = S_HY;
      S_HY:
        if (r_timer == C_YEL)
          w_next = S_AR1;
      S_AR1:
        if (r_timer == C_ARD)
          w_next = S_LG;
      S_LG:
        if ((r_timer >= C_GML && !w_sens) ||
            r_timer == C_GXL)
          w_next = S_LY;
      S_LY:
        if (r_timer == C_YEL)
          w_next = S_AR2;
      S_AR2:
        if (r_timer == C_ARD)
          w_next = S_HG;
      default:
        w_next = S_HG;
    endcase
  end

  // Timer restarts on every state change and saturates while HG waits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_HG;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_timer <= '0;
      else if (r_timer != C_SAT)
        r_timer <= r_timer + C_ONE;
    end
  end

  assign w_lamps = lamp_decode(r_state);
  assign H       = w_lamps.h;
  assign L       = w_lamps.l;
  assign STATE   = r_state;

endmodule

// File: tb/tb_tlc_param_controller.sv
// Scoreboard bench for tlc_param_controller: expected phase
// sequences are queued by stimulus, a negedge monitor checks them.
module tb_tlc_param_controller;

`ifdef TLC_SENSOR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SENSOR = 1'b0;
  logic [2:0] H;
  logic [2:0] L;
  logic [2:0] STATE;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] st;
    int         len;
  } ph_t;

  ph_t        q[$];
  ph_t        e;
  logic [2:0] cur_st = 3'd0;
  int         cur_len = 0;

  tlc_param_controller dut (
    .CLK   (CLK),
    .RST   (RST),
    .SENSOR(SENSOR),
    .H     (H),
    .L     (L),
    .STATE (STATE)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [2:0] s, input int n);
    ph_t p;
    p.st = s;
    p.len = n;
    q.push_back(p);
  endtask

  function automatic logic [5:0] lamps(input logic [2:0] s);
    case (s)
      3'd0: return 6'b001_100;
      3'd1: return 6'b010_100;
      3'd2: return 6'b100_100;
      3'd3: return 6'b100_001;
      3'd4: return 6'b100_010;
      3'd5: return 6'b100_100;
      default: return 6'b000_000;
    endcase
  endfunction

  // Monitor: a state change completes a phase, compared with the queue head
  always @(negedge CLK) begin
    if (!RST) begin
      chk("reset_outputs", {H, L, STATE}, 9'b001_100_000);
      cur_st = 3'd0;
      cur_len = 0;
    end else begin
      chk("onehot", ($onehot(H) && $onehot(L)) ? 1 : 0, 1);
      if (STATE <= 3'd5)
        chk("lamps", {H, L}, lamps(STATE));
      if (STATE != cur_st) begin
        if (q.size() == 0) begin
          chk("unexpected_phase_change", STATE, cur_st);
        end else begin
          e = q.pop_front();
          chk("phase_state", cur_st, e.st);
          chk("phase_len", cur_len, e.len);
        end
        cur_st = STATE;
        cur_len = 1;
      end else begin
        cur_len++;
      end
    end
  end

  task automatic do_reset(input logic sens);
    @(posedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    RST = 1'b0;
    SENSOR = sens;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    // Idle highway: HG held, timer saturates
    do_reset(1'b0);
    repeat (300) @(posedge CLK);
    #1;
    chk("timer_saturated", dut.r_timer, 255);
    chk("idle_state", STATE, 0);

    // Sensor held: full cycle with LG capped at max
    do_reset(1'b1);
    push(3'd0, 8);
    push(3'd1, 3);
    push(3'd2, 1);
    push(3'd3, 12);
    push(3'd4, 3);
    push(3'd5, 1);
    push(3'd0, 8);
    repeat (37) @(posedge CLK);

    // Sensor drops at LG timer 1: LG served minimum
    do_reset(1'b1);
    push(3'd0, 8);
    push(3'd1, 3);
    push(3'd2, 1);
    push(3'd3, 4);
    push(3'd4, 3);
    push(3'd5, 1);
    repeat (13) @(posedge CLK);
    #1 SENSOR = 1'b0;
    repeat (26) @(posedge CLK);

    // Late sensor at HG timer 20, dropped once HY starts
    do_reset(1'b0);
    push(3'd0, 21 + SL);
    push(3'd1, 3);
    push(3'd2, 1);
    push(3'd3, 4);
    push(3'd4, 3);
    push(3'd5, 1);
    repeat (20) @(posedge CLK);
    #1 SENSOR = 1'b1;
    repeat (SL + 1) @(posedge CLK);
    #1;
    chk("hy_entered", STATE, 1);
    SENSOR = 1'b0;
    repeat (18) @(posedge CLK);

    // Async reset during LG timer 5
    do_reset(1'b1);
    push(3'd0, 8);
    push(3'd1, 3);
    push(3'd2, 1);
    repeat (17) @(posedge CLK);
    #1;
    chk("lg_before_reset", STATE, 3);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_h", H, 3'b001);
    chk("async_rst_l", L, 3'b100);
    chk("async_rst_state", STATE, 0);
    chk("async_rst_timer", dut.r_timer, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    push(3'd0, 8);
    repeat (9) @(posedge CLK);

    // Illegal state code recovers to HG in one edge
    do_reset(1'b0);
    push(3'd0, 5);
    push(3'd7, 1);
    repeat (5) @(posedge CLK);
    #1 dut.r_state = 3'd7;
    @(posedge CLK);
    #1;
    chk("illegal_recover_state", STATE, 0);
    chk("illegal_recover_timer", dut.r_timer, 0);
    chk("illegal_recover_lamps", {H, L}, 6'b001_100);
    repeat (10) @(posedge CLK);

    @(posedge CLK);
    #1;
    chk("queue_drained_final", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
